// File: rtl/scaler_pkg.sv
// Shared scaler definitions: writer FSM states,
// pixel format widths and RGB field widths.
package scaler_pkg;

  localparam int RGB565_WIDTH = 16;
  localparam int RGB888_WIDTH = 24;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_LINE  = 3'd1;
  localparam logic [2:0] WRITE      = 3'd2;
  localparam logic [2:0] SKIP       = 3'd3;
  localparam logic [2:0] DROP       = 3'd4;
  localparam logic [2:0] FRAME_DONE = 3'd5;

  function automatic int rWidth(input int dataWidth);
    return (dataWidth == RGB888_WIDTH) ? 8 : 5;
  endfunction

  function automatic int gWidth(input int dataWidth);
    return (dataWidth == RGB888_WIDTH) ? 8 : 6;
  endfunction

  function automatic int bWidth(input int dataWidth);
    return (dataWidth == RGB888_WIDTH) ? 8 : 5;
  endfunction

  localparam int PIXEL_WIDTH = RGB565_WIDTH;
  localparam int R_WIDTH = rWidth(PIXEL_WIDTH);
  localparam int G_WIDTH = gWidth(PIXEL_WIDTH);
  localparam int B_WIDTH = bWidth(PIXEL_WIDTH);

endpackage

// File: rtl/line_ptr_ring.sv
// Line ring bookkeeping: write/read line pointers,
// fill count, retire clamp and sticky underflow.
module line_ptr_ring
  import scaler_pkg::*;
#(
  parameter int NUM_LINES      = 4,
  parameter int BUFFER_SIZE    = 3,
  parameter int LINE_SEL_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      jmp1,
  input  logic                      jmp2,
  input  logic                      inProg,
  input  logic                      lineStart,
  output logic [LINE_SEL_WIDTH-1:0] wrLine,
  output logic [LINE_SEL_WIDTH-1:0] startLine,
  output logic [LINE_SEL_WIDTH-1:0] rdLine,
  output logic [BUFFER_SIZE-1:0]    fifoNum,
  output logic [BUFFER_SIZE-1:0]    fifoPost,
  output logic                      underflow
);

  localparam int SW = LINE_SEL_WIDTH + 1;

  logic                   wrUsed;
  logic [BUFFER_SIZE-1:0] committed;
  logic [BUFFER_SIZE-1:0] req;
  logic [BUFFER_SIZE-1:0] take;

  function automatic logic [LINE_SEL_WIDTH-1:0] incMod(
    input logic [LINE_SEL_WIDTH-1:0] a,
    input logic [1:0]                n
  );
    logic [SW-1:0] s;
    s = {1'b0, a} + SW'(n);
    if (s >= SW'(NUM_LINES))
      s = s - SW'(NUM_LINES);
    return s[LINE_SEL_WIDTH-1:0];
  endfunction

  // Retire request clamped to lines already committed
  always_comb begin
    committed = fifoNum - BUFFER_SIZE'(inProg);
    req = '0;
    if (jmp2)
      req = BUFFER_SIZE'(2);
    else if (jmp1)
      req = BUFFER_SIZE'(1);
    take = (req > committed) ? committed : req;
    fifoPost = fifoNum - take;
  end

  assign startLine = wrUsed ? incMod(wrLine, 2'd1) : wrLine;

  // Pointer, count and underflow state
  always_ff @(posedge clk) begin
    if (rst) begin
      wrLine    <= '0;
      rdLine    <= '0;
      fifoNum   <= '0;
      wrUsed    <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wrLine  <= '0;
      rdLine  <= '0;
      fifoNum <= '0;
      wrUsed  <= 1'b0;
    end else begin
      rdLine  <= incMod(rdLine, take[1:0]);
      fifoNum <= fifoPost + BUFFER_SIZE'(lineStart);
      if (req > committed)
        underflow <= 1'b1;
      if (lineStart) begin
        wrLine <= startLine;
        wrUsed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/scaler_line_writer.sv
// Scaler line FIFO write side: pixel stream into a ring of line RAMs.
// Optional LINE_WRITER_DROP_CNT_EN adds the saturating dropCnt output.
module scaler_line_writer
  import scaler_pkg::*;
#(
  parameter int DATA_WIDTH     = RGB565_WIDTH,
  parameter int ADDRESS_WIDTH  = 11,
  parameter int BUFFER_SIZE    = 3,
  parameter int NUM_LINES      = 4,
  parameter int LINE_SEL_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     dIn,
  input  logic                      dInEn,
  input  logic                      HSIn,
  input  logic                      VSIn,
  input  logic [ADDRESS_WIDTH-1:0]  inXNum,
  input  logic [ADDRESS_WIDTH-1:0]  inYNum,
  input  logic                      jmp1,
  input  logic                      jmp2,
  output logic                      ramWrEn,
  output logic [LINE_SEL_WIDTH-1:0] ramWrLine,
  output logic [ADDRESS_WIDTH-1:0]  ramWrAddr,
  output logic [DATA_WIDTH-1:0]     ramWrData,
  output logic [ADDRESS_WIDTH-1:0]  ramAddrIn,
  output logic [LINE_SEL_WIDTH-1:0] rdLine,
  output logic [BUFFER_SIZE-1:0]    fifoNum,
  output logic                      overflow,
  output logic                      underflow
`ifdef LINE_WRITER_DROP_CNT_EN
  , output logic [7:0]              dropCnt
`endif
);

  localparam int AW = ADDRESS_WIDTH;

  logic [2:0]                state;
  logic [AW-1:0]             xCnt;
  logic [AW-1:0]             yCount;
  logic [AW-1:0]             yInc;
  logic [AW-1:0]             xNext;
  logic [LINE_SEL_WIDTH-1:0] wrLine;
  logic [LINE_SEL_WIDTH-1:0] startLine;
  logic [BUFFER_SIZE-1:0]    fifoPost;
  logic                      inWait;
  logic                      full;
  logic                      lineStart;
  logic                      lineDrop;
  logic                      acc;
  logic                      accAny;
  logic                      reach;

  assign inWait    = !VSIn && (state == WAIT_LINE);
  assign full      = fifoPost >= BUFFER_SIZE'(NUM_LINES);
  assign lineStart = inWait && dInEn && !full;
  assign lineDrop  = inWait && dInEn && full;
  assign acc       = !VSIn && (state == WRITE)
                     && dInEn && (xCnt < inXNum);
  assign accAny    = lineStart || acc;
  assign xNext     = lineStart ? AW'(1) : xCnt + AW'(1);
  assign reach     = accAny && (xNext == inXNum);
  assign yInc      = yCount + AW'(1);

  line_ptr_ring #(
    .NUM_LINES      (NUM_LINES),
    .BUFFER_SIZE    (BUFFER_SIZE),
    .LINE_SEL_WIDTH (LINE_SEL_WIDTH)
  ) uRing (
    .clk       (clk),
    .rst       (rst),
    .flush     (VSIn),
    .jmp1      (jmp1),
    .jmp2      (jmp2),
    .inProg    (state == WRITE),
    .lineStart (lineStart),
    .wrLine    (wrLine),
    .startLine (startLine),
    .rdLine    (rdLine),
    .fifoNum   (fifoNum),
    .fifoPost  (fifoPost),
    .underflow (underflow)
  );

  // Line FSM with column/row counters and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      xCnt     <= '0;
      yCount   <= '0;
      overflow <= 1'b0;
    end else if (VSIn) begin
      xCnt   <= '0;
      yCount <= '0;
      if (inXNum == '0 || inYNum == '0)
        state <= FRAME_DONE;
      else
        state <= WAIT_LINE;
    end else begin
      unique case (state)
        WAIT_LINE: begin
          if (lineStart) begin
            xCnt <= xNext;
            if (reach) begin
              yCount <= yInc;
              state  <= SKIP;
            end else begin
              state <= WRITE;
            end
          end else if (lineDrop) begin
            overflow <= 1'b1;
            state    <= DROP;
          end
        end
        WRITE: begin
          if (acc)
            xCnt <= xNext;
          if (reach || HSIn) begin
            yCount <= yInc;
            if (!HSIn)
              state <= SKIP;
            else if (yInc == inYNum)
              state <= FRAME_DONE;
            else
              state <= WAIT_LINE;
          end
        end
        SKIP: begin
          if (HSIn)
            state <= (yCount == inYNum) ? FRAME_DONE : WAIT_LINE;
        end
        DROP: begin
          if (HSIn) begin
            yCount <= yInc;
            state  <= (yInc == inYNum) ? FRAME_DONE : WAIT_LINE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // One-cycle write register toward the line RAMs
  always_ff @(posedge clk) begin
    if (rst) begin
      ramWrEn   <= 1'b0;
      ramWrLine <= '0;
      ramWrAddr <= '0;
      ramWrData <= '0;
    end else begin
      ramWrEn <= accAny;
      if (accAny) begin
        ramWrLine <= lineStart ? startLine : wrLine;
        ramWrAddr <= lineStart ? '0 : xCnt;
        ramWrData <= dIn;
      end
    end
  end

  // Published column count trails the RAM write by a cycle
  always_ff @(posedge clk) begin
    if (rst)
      ramAddrIn <= '0;
    else if (VSIn || lineStart)
      ramAddrIn <= '0;
    else if (ramWrEn)
      ramAddrIn <= ramAddrIn + AW'(1);
  end

`ifdef LINE_WRITER_DROP_CNT_EN
  // Saturating count of dropped lines
  always_ff @(posedge clk) begin
    if (rst)
      dropCnt <= '0;
    else if (lineDrop && dropCnt != 8'hFF)
      dropCnt <= dropCnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_scaler_line_writer.sv
// Scoreboard bench for scaler_line_writer:
// reference model of the line ring plus directed and random traffic.
module tb_scaler_line_writer;

  localparam int NL = 4;

  logic        clk;
  logic        rst;
  logic [15:0] dIn;
  logic        dInEn;
  logic        HSIn;
  logic        VSIn;
  logic [10:0] inXNum;
  logic [10:0] inYNum;
  logic        jmp1;
  logic        jmp2;
  logic        ramWrEn;
  logic [1:0]  ramWrLine;
  logic [10:0] ramWrAddr;
  logic [15:0] ramWrData;
  logic [10:0] ramAddrIn;
  logic [1:0]  rdLine;
  logic [2:0]  fifoNum;
  logic        overflow;
  logic        underflow;
`ifdef LINE_WRITER_DROP_CNT_EN
  logic [7:0]  dropCnt;
`endif

  scaler_line_writer dut (
    .clk       (clk),
    .rst       (rst),
    .dIn       (dIn),
    .dInEn     (dInEn),
    .HSIn      (HSIn),
    .VSIn      (VSIn),
    .inXNum    (inXNum),
    .inYNum    (inYNum),
    .jmp1      (jmp1),
    .jmp2      (jmp2),
    .ramWrEn   (ramWrEn),
    .ramWrLine (ramWrLine),
    .ramWrAddr (ramWrAddr),
    .ramWrData (ramWrData),
    .ramAddrIn (ramAddrIn),
    .rdLine    (rdLine),
    .fifoNum   (fifoNum),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef LINE_WRITER_DROP_CNT_EN
    , .dropCnt (dropCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int wrCount = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int line;
    int addr;
    int data;
  } wr_t;

  wr_t expQ[$];

  localparam int P_IDLE = 0;
  localparam int P_GAP  = 1;
  localparam int P_LINE = 2;
  localparam int P_TAIL = 3;
  localparam int P_DROP = 4;
  localparam int P_DONE = 5;

  int phase = P_IDLE;
  int mCnt = 0;
  int mRd = 0;
  int mX = 0;
  int mY = 0;
  int mAddr = 0;
  int mLine = 0;
  int mDrops = 0;
  bit mPend = 0;
  bit mInProg = 0;
  bit mOv = 0;
  bit mUf = 0;

  always @(posedge clk) begin
    int n;
    int avail;
    bit start;
    bit issued;
    wr_t w;
    start = 0;
    issued = 0;
    if (rst) begin
      phase = P_IDLE;
      mCnt = 0; mRd = 0; mX = 0; mY = 0; mAddr = 0;
      mDrops = 0; mPend = 0; mInProg = 0; mOv = 0; mUf = 0;
      expQ.delete();
    end else if (VSIn) begin
      mCnt = 0; mRd = 0; mY = 0; mAddr = 0;
      mPend = 0; mInProg = 0;
      phase = (inXNum == 0 || inYNum == 0) ? P_DONE : P_GAP;
    end else begin
      n = jmp2 ? 2 : (jmp1 ? 1 : 0);
      avail = mCnt - (mInProg ? 1 : 0);
      if (n > avail) begin
        mUf = 1;
        n = avail;
      end
      mRd = (mRd + n) % NL;
      mCnt = mCnt - n;
      case (phase)
        P_GAP: if (dInEn) begin
          if (mCnt < NL) begin
            mLine = (mRd + mCnt) % NL;
            mCnt++;
            mInProg = 1;
            mX = 0;
            start = 1;
            phase = P_LINE;
          end else begin
            mOv = 1;
            if (mDrops < 255) mDrops++;
            phase = P_DROP;
          end
        end
        P_DROP: if (HSIn) begin
          mY++;
          phase = (mY == int'(inYNum)) ? P_DONE : P_GAP;
        end
        P_TAIL: if (HSIn)
          phase = (mY == int'(inYNum)) ? P_DONE : P_GAP;
        default: ;
      endcase
      if (phase == P_LINE) begin
        if (dInEn && mX < int'(inXNum)) begin
          w.line = mLine;
          w.addr = mX;
          w.data = int'(dIn);
          expQ.push_back(w);
          mX++;
          issued = 1;
        end
        if (mX == int'(inXNum) || (HSIn && !start)) begin
          mInProg = 0;
          mY++;
          if (HSIn && !start)
            phase = (mY == int'(inYNum)) ? P_DONE : P_GAP;
          else
            phase = P_TAIL;
        end
      end
      if (start)
        mAddr = 0;
      else if (mPend)
        mAddr++;
      mPend = issued;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    wr_t e;
    check("ramWrEn", int'(ramWrEn), int'(expQ.size() != 0));
    if (ramWrEn) wrCount++;
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      if (ramWrEn) begin
        check("ramWrLine", int'(ramWrLine), e.line);
        check("ramWrAddr", int'(ramWrAddr), e.addr);
        check("ramWrData", int'(ramWrData), e.data);
      end
    end
    check("fifoNum", int'(fifoNum), mCnt);
    check("rdLine", int'(rdLine), mRd);
    check("ramAddrIn", int'(ramAddrIn), mAddr);
    check("overflow", int'(overflow), int'(mOv));
    check("underflow", int'(underflow), int'(mUf));
`ifdef LINE_WRITER_DROP_CNT_EN
    check("dropCnt", int'(dropCnt), mDrops);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic de, input logic [15:0] d,
                     input logic hs, input logic vs,
                     input logic j1, input logic j2);
    dInEn = de; dIn = d; HSIn = hs; VSIn = vs;
    jmp1 = j1; jmp2 = j2;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 16'h0, 0, 0, 0, 0);
  endtask

  task automatic vsync();
    cyc(0, 16'h0, 0, 1, 0, 0);
  endtask

  task automatic pixels(input int n);
    for (int i = 0; i < n; i++) cyc(1, 16'($urandom), 0, 0, 0, 0);
  endtask

  task automatic line(input int n);
    pixels(n);
    cyc(0, 16'h0, 1, 0, 0, 0);
    idle(2);
  endtask

  int wBase;
  int len;

  initial begin
    rst = 1;
    dIn = '0; dInEn = 0; HSIn = 0; VSIn = 0;
    jmp1 = 0; jmp2 = 0;
    inXNum = 11'd8; inYNum = 11'd3;

    // 1: reset with random input, then input before VSIn
    for (int i = 0; i < 2; i++)
      cyc(1'($urandom), 16'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom));
    check("rst ramWrEn", int'(ramWrEn), 0);
    check("rst fifoNum", int'(fifoNum), 0);
    check("rst ramAddrIn", int'(ramAddrIn), 0);
    check("rst rdLine", int'(rdLine), 0);
    check("rst ramWrData", int'(ramWrData), 0);
    check("rst overflow", int'(overflow), 0);
    rst = 0;
    pixels(5);
    idle(2);
    check("idle writes", wrCount, 0);

    // 2: three 10-pixel lines
    vsync();
    wBase = wrCount;
    line(10);
    check("s2 fifoNum l1", int'(fifoNum), 1);
    line(10);
    line(10);
    check("s2 fifoNum", int'(fifoNum), 3);
    check("s2 ramAddrIn", int'(ramAddrIn), 8);
    check("s2 writes", wrCount - wBase, 24);

    // 3: ring overflow
    inYNum = 11'd6;
    vsync();
    wBase = wrCount;
    for (int l = 0; l < 5; l++) line(10);
    check("s3 fifoNum", int'(fifoNum), 4);
    check("s3 overflow", int'(overflow), 1);
    check("s3 writes", wrCount - wBase, 32);
`ifdef LINE_WRITER_DROP_CNT_EN
    check("s3 dropCnt", int'(dropCnt), 1);
`endif

    // 4: rdLine wrap and underflow
    vsync();
    for (int l = 0; l < 3; l++) line(10);
    for (int i = 0; i < 3; i++) cyc(0, 16'h0, 0, 0, 1, 0);
    for (int l = 0; l < 3; l++) line(10);
    check("s4 rdLine pre", int'(rdLine), 3);
    check("s4 fifoNum pre", int'(fifoNum), 3);
    cyc(0, 16'h0, 0, 0, 0, 1);
    check("s4 rdLine wrap", int'(rdLine), 1);
    check("s4 fifoNum", int'(fifoNum), 1);
    cyc(0, 16'h0, 0, 0, 1, 1);
    check("s4 fifoNum empty", int'(fifoNum), 0);
    check("s4 underflow", int'(underflow), 1);
    idle(2);

    // 5: retire frees a slot as a line starts
    vsync();
    for (int l = 0; l < 4; l++) line(10);
    cyc(1, 16'hBEEF, 0, 0, 1, 0);
    check("s5 ramWrEn", int'(ramWrEn), 1);
    check("s5 ramWrLine", int'(ramWrLine), 0);
    check("s5 fifoNum", int'(fifoNum), 4);
    check("s5 rdLine", int'(rdLine), 1);
    pixels(9);
    cyc(0, 16'h0, 1, 0, 0, 0);
    idle(2);

    // 6: VSIn mid-line
    inYNum = 11'd3;
    vsync();
    line(10);
    pixels(5);
    vsync();
    check("s6 fifoNum", int'(fifoNum), 0);
    check("s6 ramAddrIn", int'(ramAddrIn), 0);
    check("s6 rdLine", int'(rdLine), 0);
    cyc(1, 16'h1234, 0, 0, 0, 0);
    check("s6 ramWrLine", int'(ramWrLine), 0);
    check("s6 ramWrAddr", int'(ramWrAddr), 0);
    pixels(9);
    cyc(0, 16'h0, 1, 0, 0, 0);
    idle(2);

    // zero-sized frame
    inXNum = 11'd0;
    vsync();
    wBase = wrCount;
    line(10);
    check("zero writes", wrCount - wBase, 0);
    check("zero fifoNum", int'(fifoNum), 0);

    // random frames
    for (int f = 0; f < 14; f++) begin
      inXNum = 11'($urandom_range(1, 8));
      inYNum = 11'($urandom_range(1, 7));
      vsync();
      for (int l = 0; l < 9; l++) begin
        len = $urandom_range(1, 11);
        for (int p = 0; p < len; p++) begin
          if ($urandom_range(0, 3) == 0)
            cyc(0, 16'($urandom), 0, 0,
                1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 9) == 0));
          cyc(1, 16'($urandom), 0, 0,
              1'($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 9) == 0));
        end
        if ($urandom_range(0, 24) == 0) begin
          vsync();
        end else begin
          cyc(0, 16'h0, 1, 0,
              1'($urandom_range(0, 5) == 0), 0);
        end
        for (int g = 0; g < int'($urandom_range(0, 3)); g++)
          cyc(0, 16'h0, 0, 0,
              1'($urandom_range(0, 4) == 0),
              1'($urandom_range(0, 6) == 0));
      end
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
